// File: rtl/ust_pkg.sv
// Shared types and saturation helpers for the unary-temporal (uSystolic) accumulator PEs.
package ust_pkg;

    typedef enum logic [1:0] {IDLE, RUN, ADD, HOLD} state_e;

    localparam int UST_WIDTH     = 16;
    localparam int UST_ACC_WIDTH = 32;

    localparam logic signed [UST_ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(UST_ACC_WIDTH-1){1'b1}}};
    localparam logic signed [UST_ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(UST_ACC_WIDTH-1){1'b0}}};

    // Default-width reference of the add/saturate step, for PEs that do not need a sub-module.
    function automatic logic signed [UST_ACC_WIDTH-1:0] sat_add(
        input logic signed [UST_ACC_WIDTH-1:0] psum,
        input logic        [UST_WIDTH-2:0]     ones,
        input logic                            sgn
    );
        logic signed [UST_ACC_WIDTH:0] p_x;
        logic signed [UST_ACC_WIDTH:0] o_x;
        logic signed [UST_ACC_WIDTH:0] s_x;
        p_x = {psum[UST_ACC_WIDTH-1], psum};
        o_x = {{(UST_ACC_WIDTH-UST_WIDTH+2){1'b0}}, ones};
        s_x = sgn ? (p_x - o_x) : (p_x + o_x);
        if (s_x[UST_ACC_WIDTH] != s_x[UST_ACC_WIDTH-1])
            return s_x[UST_ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        return s_x[UST_ACC_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/ust_sat_add.sv
// Combinational signed add of a sign-magnitude ones count onto a partial sum, saturated to ACC_WIDTH.
module ust_sat_add #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 32
) (
    input  logic [ACC_WIDTH-1:0] psum_i,
    input  logic [WIDTH-2:0]     ones_i,
    input  logic                 sgn_i,
    output logic [ACC_WIDTH-1:0] sum_o
);

    localparam logic [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH:0] psum_x;
    logic signed [ACC_WIDTH:0] ones_x;
    logic signed [ACC_WIDTH:0] sum_x;

    assign psum_x = {psum_i[ACC_WIDTH-1], psum_i};
    assign ones_x = {{(ACC_WIDTH-WIDTH+2){1'b0}}, ones_i};

    // A zero count subtracts nothing, so sign-magnitude -0 behaves as +0.
    assign sum_x = sgn_i ? (psum_x - ones_x) : (psum_x + ones_x);

    always_comb begin
        sum_o = sum_x[ACC_WIDTH-1:0];
        if (sum_x[ACC_WIDTH] != sum_x[ACC_WIDTH-1])
            sum_o = sum_x[ACC_WIDTH] ? SAT_MIN : SAT_MAX;
    end

endmodule

// File: rtl/ust_accum_border.sv
// Border accumulator: counts product-stream ones over a MAC window, applies the sign,
// adds it to the upstream partial sum with saturation and hands the result on via valid/ready.
module ust_accum_border
    import ust_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 init,
    input  logic                 clr,
    input  logic [WIDTH-2:0]     i_len,
    input  logic                 i_sign,
    input  logic                 i_bit,
    input  logic [ACC_WIDTH-1:0] i_psum,
    input  logic                 i_psum_valid,
    output logic                 o_psum_ready,
    output logic [ACC_WIDTH-1:0] o_psum,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_busy,
    output logic                 o_err
);

    state_e                 state_q;
    logic [WIDTH-2:0]       rem_q;
    logic [WIDTH-2:0]       ones_q;
    logic                   sgn_q;
    logic                   valid_q;
    logic                   err_q;
    logic [ACC_WIDTH-1:0]   psum_q;
    logic [ACC_WIDTH-1:0]   psum_d;
    logic                   xfer;
    logic                   init_acc;

    // A new window may start from IDLE, or from HOLD in the same cycle the result leaves.
    assign xfer         = (state_q == HOLD) && valid_q && i_ready;
    assign init_acc     = init && !clr && ((state_q == IDLE) || xfer);
    assign o_psum_ready = (state_q == ADD) && i_psum_valid && !clr;

    assign o_psum = psum_q;
    assign o_valid = valid_q;
    assign o_err  = err_q;
    assign o_busy = (state_q != IDLE);

    ust_sat_add #(
        .WIDTH     (WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_sat_add (
        .psum_i (i_psum),
        .ones_i (ones_q),
        .sgn_i  (sgn_q),
        .sum_o  (psum_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            ones_q  <= '0;
            sgn_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            psum_q  <= '0;
        end else if (clr) begin
            state_q <= IDLE;
            ones_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            if (init && !init_acc)
                err_q <= 1'b1;

            // The init cycle's bit is not counted: RUN covers exactly the next rem cycles.
            if (init_acc) begin
                rem_q   <= i_len;
                sgn_q   <= i_sign;
                ones_q  <= '0;
                state_q <= (i_len == '0) ? ADD : RUN;
            end

            case (state_q)
                IDLE: ;
                RUN: begin
                    ones_q <= ones_q + {{(WIDTH-2){1'b0}}, i_bit};
                    rem_q  <= rem_q - (WIDTH-1)'(1);
                    if (rem_q == (WIDTH-1)'(1))
                        state_q <= ADD;
                end
                ADD: begin
                    if (i_psum_valid) begin
                        psum_q  <= psum_d;
                        valid_q <= 1'b1;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (i_ready) begin
                        valid_q <= 1'b0;
                        if (!init_acc)
                            state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ust_accum_border.sv
// Self-checking bench for ust_accum_border: directed MAC cases plus randomized windows
// compared every cycle against a transaction-level model.
module tb_ust_accum_border;

    localparam int WIDTH     = 16;
    localparam int ACC_WIDTH = 32;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 init;
    logic                 clr;
    logic [WIDTH-2:0]     i_len;
    logic                 i_sign;
    logic                 i_bit;
    logic [ACC_WIDTH-1:0] i_psum;
    logic                 i_psum_valid;
    logic                 o_psum_ready;
    logic [ACC_WIDTH-1:0] o_psum;
    logic                 o_valid;
    logic                 i_ready;
    logic                 o_busy;
    logic                 o_err;

    ust_accum_border #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .init         (init),
        .clr          (clr),
        .i_len        (i_len),
        .i_sign       (i_sign),
        .i_bit        (i_bit),
        .i_psum       (i_psum),
        .i_psum_valid (i_psum_valid),
        .o_psum_ready (o_psum_ready),
        .o_psum       (o_psum),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_busy       (o_busy),
        .o_err        (o_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: what the outputs must show in the current cycle.
    logic                 exp_valid  = 1'b0;
    logic                 exp_busy   = 1'b0;
    logic                 exp_err    = 1'b0;
    logic                 exp_pready = 1'b0;
    logic [ACC_WIDTH-1:0] exp_psum   = '0;
    bit                   chk_en     = 1'b0;
    int                   cur_len;
    int                   cur_ones;
    bit                   cur_sgn;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_sum(input logic [31:0] psum, input int ones, input bit sgn);
        longint s;
        s = longint'($signed(psum)) + (sgn ? -longint'(ones) : longint'(ones));
        if (s > 64'sd2147483647)  s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
        return s[31:0];
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("o_valid", {31'b0, o_valid}, {31'b0, exp_valid});
            chk("o_busy", {31'b0, o_busy}, {31'b0, exp_busy});
            chk("o_err", {31'b0, o_err}, {31'b0, exp_err});
            chk("o_psum_ready", {31'b0, o_psum_ready}, {31'b0, exp_pready});
            if (exp_valid)
                chk("o_psum", o_psum, exp_psum);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_init(input int len, input bit sgn);
        init   = 1'b1;
        i_len  = (WIDTH-1)'(len);
        i_sign = sgn;
        i_bit  = 1'($urandom);
        tick();
        init     = 1'b0;
        exp_busy = 1'b1;
        cur_len  = len;
        cur_sgn  = sgn;
        cur_ones = 0;
    endtask

    task automatic do_bits(input logic [63:0] pat, input int err_at);
        logic [63:0] p;
        p = pat;
        for (int k = 0; k < cur_len; k++) begin
            i_bit = p[k];
            cur_ones += int'(p[k]);
            if (k == err_at) begin
                init   = 1'b1;
                i_len  = (WIDTH-1)'($urandom);
                i_sign = 1'($urandom);
            end
            tick();
            if (k == err_at) begin
                init    = 1'b0;
                exp_err = 1'b1;
            end
        end
        i_bit = 1'b1;
    endtask

    task automatic do_add(input logic [31:0] psum, input int pdly);
        i_psum = $urandom;
        for (int d = 0; d < pdly; d++) begin
            i_bit = 1'($urandom);
            tick();
        end
        i_psum       = psum;
        i_psum_valid = 1'b1;
        exp_pready   = 1'b1;
        tick();
        i_psum_valid = 1'b0;
        exp_pready   = 1'b0;
        exp_valid    = 1'b1;
        exp_psum     = model_sum(psum, cur_ones, cur_sgn);
    endtask

    task automatic do_hold(input int rdly, input bit chain, input int nlen, input bit nsgn);
        for (int r = 0; r < rdly; r++) begin
            i_psum       = $urandom;
            i_psum_valid = 1'($urandom);
            tick();
        end
        i_psum_valid = 1'b0;
        i_ready      = 1'b1;
        if (chain) begin
            init   = 1'b1;
            i_len  = (WIDTH-1)'(nlen);
            i_sign = nsgn;
        end
        tick();
        i_ready   = 1'b0;
        init      = 1'b0;
        exp_valid = 1'b0;
        exp_busy  = chain;
        if (chain) begin
            cur_len  = nlen;
            cur_sgn  = nsgn;
            cur_ones = 0;
        end
    endtask

    task automatic mac_lit(input string name, input int len, input bit sgn, input logic [63:0] pat,
                           input logic [31:0] psum, input logic [31:0] lit, input int rdly);
        do_init(len, sgn);
        do_bits(pat, -1);
        do_add(psum, 0);
        @(negedge clk);
        chk(name, o_psum, lit);
        do_hold(rdly, 1'b0, 0, 1'b0);
    endtask

    initial begin
        bit          pending;
        int          len;
        int          nlen;
        bit          sgn;
        bit          nsgn;
        bit          chain;
        logic [63:0] pat;
        logic [31:0] psum;

        rst_n = 1'b0; init = 1'b0; clr = 1'b0; i_len = '0; i_sign = 1'b0; i_bit = 1'b0;
        i_psum = '0; i_psum_valid = 1'b0; i_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset o_valid", {31'b0, o_valid}, 32'd0);
        chk("reset o_psum", o_psum, 32'd0);
        chk("reset o_busy", {31'b0, o_busy}, 32'd0);
        chk("reset o_err", {31'b0, o_err}, 32'd0);
        chk("reset o_psum_ready", {31'b0, o_psum_ready}, 32'd0);
        tick();
        rst_n  = 1'b1;
        chk_en = 1'b1;
        tick();

        // Directed cases with hand-computed results.
        mac_lit("basic", 4, 1'b0, 64'b1101, 32'd100, 32'd103, 5);
        mac_lit("neg5", 8, 1'b1, 64'b10110101, 32'd2, 32'hFFFF_FFFD, 0);
        mac_lit("neg0", 8, 1'b1, 64'd0, 32'd2, 32'd2, 1);
        mac_lit("sat_hi", 32, 1'b0, 64'hFFFF_FFFF, 32'h7FFF_FFF0, 32'h7FFF_FFFF, 0);
        mac_lit("sat_lo", 16, 1'b1, 64'hFFFF, 32'h8000_0005, 32'h8000_0000, 2);
        mac_lit("zero_len", 0, 1'b0, 64'hFFFF, 32'd77, 32'd77, 0);

        // Abort in the third RUN cycle; the concurrent init must not flag an error.
        do_init(8, 1'b0);
        i_bit = 1'b1;
        tick();
        tick();
        clr  = 1'b1;
        init = 1'b1;
        tick();
        clr      = 1'b0;
        init     = 1'b0;
        exp_busy = 1'b0;
        repeat (3) tick();
        mac_lit("after_clr", 2, 1'b0, 64'b00, 32'd10, 32'd10, 0);

        // Result handed over with a new init in the same cycle.
        do_init(3, 1'b0);
        do_bits(64'b111, -1);
        do_add(32'd20, 1);
        @(negedge clk);
        chk("chain_first", o_psum, 32'd23);
        do_hold(2, 1'b1, 4, 1'b0);
        do_bits(64'b1111, -1);
        do_add(32'hFFFF_FFF6, 0);
        @(negedge clk);
        chk("chain_second", o_psum, 32'hFFFF_FFFA);
        do_hold(0, 1'b0, 0, 1'b0);

        // Init during RUN is ignored but makes o_err stick.
        do_init(6, 1'b0);
        do_bits(64'b101011, 2);
        do_add(32'd1000, 0);
        @(negedge clk);
        chk("err_result", o_psum, 32'd1004);
        chk("err_flag", {31'b0, o_err}, 32'd1);
        do_hold(0, 1'b0, 0, 1'b0);

        // Randomized windows.
        pending = 1'b0;
        nlen    = 0;
        nsgn    = 1'b0;
        for (int t = 0; t < 40; t++) begin
            pat = {$urandom, $urandom};
            case ($urandom_range(0, 2))
                0:       psum = $urandom;
                1:       psum = 32'h7FFF_FFFF - $urandom_range(0, 30);
                default: psum = 32'h8000_0000 + $urandom_range(0, 30);
            endcase
            if (!pending) begin
                len = $urandom_range(0, 40);
                sgn = 1'($urandom);
                do_init(len, sgn);
            end
            do_bits(pat, -1);
            do_add(psum, $urandom_range(0, 3));
            chain = 1'($urandom) && (t != 39);
            nlen  = $urandom_range(0, 40);
            nsgn  = 1'($urandom);
            do_hold($urandom_range(0, 3), chain, nlen, nsgn);
            pending = chain;
        end

        // Asynchronous reset while a result is being held.
        do_init(3, 1'b0);
        do_bits(64'b111, -1);
        do_add(32'd50, 0);
        rst_n     = 1'b0;
        exp_valid = 1'b0;
        exp_busy  = 1'b0;
        exp_err   = 1'b0;
        #1;
        chk("rst_hold o_valid", {31'b0, o_valid}, 32'd0);
        chk("rst_hold o_psum", o_psum, 32'd0);
        chk("rst_hold o_busy", {31'b0, o_busy}, 32'd0);
        chk("rst_hold o_err", {31'b0, o_err}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        mac_lit("post_reset", 5, 1'b1, 64'b11011, 32'd0, 32'hFFFF_FFFC, 0);
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
